// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result handshake bundle for pipe_addsub.
// master drives operands and out_ready; slave is the adder.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, x, y, sub, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, sub, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined ripple-carry add/sub, one SW-bit slice per stage.
// Define PIPE_ADDSUB_FLAGS_EN to compute and register the ovf/zero flags.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic adv;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // R: operand bits still to be summed, PW: sum bits done after k.
        localparam int R  = WIDTH - k * SW;
        localparam int PW = (k + 1) * SW;

        logic [R-1:0]  a_in;
        logic [R-1:0]  b_in;
        logic          c_in;
        logic          v_in;
        logic [SW:0]   sl;
        logic [PW-1:0] p_d;
        logic [PW-1:0] p_q;
        logic          c_q;
        logic          v_q;

        if (k == 0) begin : g_src
            assign a_in = bus.x;
            assign b_in = bus.sub ? ~bus.y : bus.y;
            assign c_in = bus.sub ? ~bus.cin : bus.cin;
            assign v_in = bus.in_valid;
            assign p_d  = sl[SW-1:0];
        end else begin : g_src
            assign a_in = g_st[k-1].g_fw.a_q;
            assign b_in = g_st[k-1].g_fw.b_q;
            assign c_in = g_st[k-1].c_q;
            assign v_in = g_st[k-1].v_q;
            assign p_d  = {sl[SW-1:0], g_st[k-1].p_q};
        end

        assign sl = {1'b0, a_in[SW-1:0]}
                  + {1'b0, b_in[SW-1:0]}
                  + {{SW{1'b0}}, c_in};

        // Partial sum, slice carry and valid move as one on adv.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                p_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= sl[SW];
                p_q <= p_d;
            end
        end

        if (k < STAGES - 1) begin : g_fw
            logic [R-SW-1:0] a_q;
            logic [R-SW-1:0] b_q;

            // Delay the operand slices not yet consumed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[R-1:SW];
                    b_q <= b_in[R-1:SW];
                end
            end
        end else begin : g_fl
`ifdef PIPE_ADDSUB_FLAGS_EN
            logic ovf_q;
            logic zero_q;

            // Flags use the top operand slice, still present here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[R-1] == b_in[R-1])
                           && (p_d[PW-1] != a_in[R-1]);
                    zero_q <= (p_d == '0);
                end
            end

            assign bus.ovf  = ovf_q;
            assign bus.zero = zero_q;
`else
            assign bus.ovf  = 1'b0;
            assign bus.zero = 1'b0;
`endif
        end
    end

    assign bus.out_valid = g_st[STAGES-1].v_q;
    assign bus.s         = g_st[STAGES-1].p_q;
    assign bus.cout      = g_st[STAGES-1].c_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: random and directed checks of pipe_addsub against an
// arithmetic reference model, with a parameter sweep of extra instances.
module tb_pipe_addsub;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

`ifdef PIPE_ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    // Reference: plain unsigned/signed arithmetic at width w.
    function automatic res_t ref_op(input int w, input logic [63:0] a,
                                    input logic [63:0] b, input logic sb,
                                    input logic ci);
        logic [65:0]        msk, am, bm, u, cu;
        logic signed [65:0] sa, sbv, r, mx, mn, cs;
        res_t q;
        msk = (66'd1 << w) - 66'd1;
        am  = {2'b00, a} & msk;
        bm  = {2'b00, b} & msk;
        cu  = {65'd0, ci};
        cs  = $signed(cu);
        sa  = $signed(am << (66 - w)) >>> (66 - w);
        sbv = $signed(bm << (66 - w)) >>> (66 - w);
        mx  = (66'sd1 <<< (w - 1)) - 66'sd1;
        mn  = -(66'sd1 <<< (w - 1));
        if (sb) begin
            u   = am - bm - cu;
            q.c = (am >= bm + cu);
            r   = sa - sbv - cs;
        end else begin
            u   = am + bm + cu;
            q.c = u[w];
            r   = sa + sbv + cs;
        end
        u   = u & msk;
        q.s = u[63:0];
        q.o = FLAGS && ((r > mx) || (r < mn));
        q.z = FLAGS && (q.s == 64'd0);
        return q;
    endfunction

    pipe_addsub_if #(.WIDTH(32)) m();
    pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(m));

    logic        sw_valid = 1'b0;
    logic [63:0] sw_x = '0;
    logic [63:0] sw_y = '0;
    logic        sw_sub = 1'b0;
    logic        sw_cin = 1'b0;

    pipe_addsub_if #(.WIDTH(8))  i8();
    pipe_addsub_if #(.WIDTH(16)) i16();
    pipe_addsub_if #(.WIDTH(64)) i64();

    pipe_addsub #(.WIDTH(8), .STAGES(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .bus(i8));
    pipe_addsub #(.WIDTH(16), .STAGES(2)) u_d16 (
        .clk(clk), .rst_n(rst_n), .bus(i16));
    pipe_addsub #(.WIDTH(64), .STAGES(8)) u_d64 (
        .clk(clk), .rst_n(rst_n), .bus(i64));

    assign i8.in_valid   = sw_valid;
    assign i8.x          = sw_x[7:0];
    assign i8.y          = sw_y[7:0];
    assign i8.sub        = sw_sub;
    assign i8.cin        = sw_cin;
    assign i8.out_ready  = 1'b1;
    assign i16.in_valid  = sw_valid;
    assign i16.x         = sw_x[15:0];
    assign i16.y         = sw_y[15:0];
    assign i16.sub       = sw_sub;
    assign i16.cin       = sw_cin;
    assign i16.out_ready = 1'b1;
    assign i64.in_valid  = sw_valid;
    assign i64.x         = sw_x;
    assign i64.y         = sw_y;
    assign i64.sub       = sw_sub;
    assign i64.cin       = sw_cin;
    assign i64.out_ready = 1'b1;

    logic [63:0] so [3];
    logic        vo [3];
    logic        ro [3];
    logic        co [3];
    logic        oo [3];
    logic        zo [3];

    assign so[0] = {56'd0, i8.s};
    assign so[1] = {48'd0, i16.s};
    assign so[2] = i64.s;
    assign vo[0] = i8.out_valid;
    assign vo[1] = i16.out_valid;
    assign vo[2] = i64.out_valid;
    assign ro[0] = i8.in_ready;
    assign ro[1] = i16.in_ready;
    assign ro[2] = i64.in_ready;
    assign co[0] = i8.cout;
    assign co[1] = i16.cout;
    assign co[2] = i64.cout;
    assign oo[0] = i8.ovf;
    assign oo[1] = i16.ovf;
    assign oo[2] = i64.ovf;
    assign zo[0] = i8.zero;
    assign zo[1] = i16.zero;
    assign zo[2] = i64.zero;

    localparam int SWW [3] = '{8, 16, 64};
    localparam int SWS [3] = '{1, 2, 8};

    // One operation on the 32-bit DUT; lat counts cycles to out_valid.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic sb, input logic ci,
                           output logic [31:0] rs, output logic rc,
                           output logic ro_, output logic rz,
                           output int lat);
        @(negedge clk);
        m.x = a; m.y = b; m.sub = sb; m.cin = ci;
        m.in_valid = 1'b1; m.out_ready = 1'b1;
        @(negedge clk);
        m.in_valid = 1'b0;
        lat = 1;
        while (!m.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rs = m.s; rc = m.cout; ro_ = m.ovf; rz = m.zero;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({m.out_valid, m.cout, m.ovf, m.zero} !== 4'b0 || m.s !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: v=%b s=%h c=%b o=%b z=%b, want all 0",
                     m.out_valid, m.s, m.cout, m.ovf, m.zero);
        end
        vectors++;
        if (m.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", m.in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m.in_valid = 1'b1; m.out_ready = 1'b1;
            m.x = $urandom | 32'h1; m.y = '0; m.sub = 1'b0; m.cin = 1'b0;
        end
        @(negedge clk);
        m.in_valid = 1'b0; m.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (m.out_valid !== 1'b1 || m.s === 32'd0) begin
            miscompares++;
            $display("FAIL pre_reset_hold: v=%b s=%h, want v=1 s!=0",
                     m.out_valid, m.s);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m.out_valid !== 1'b0 || m.s !== 32'd0 || m.cout !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: v=%b s=%h c=%b, want 0 0 0",
                     m.out_valid, m.s, m.cout);
        end
        @(negedge clk);
        rst_n = 1'b1; m.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (m.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_after_reset: cyc %0d v=%b want 0",
                         i, m.out_valid);
            end
        end
    endtask

    task automatic test_basic_add();
        logic [31:0] rs; logic rc, rov, rz; int lat;
        run_one(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, rs, rc, rov, rz, lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL add_latency: got %0d want 4", lat);
        end
        vectors++;
        if ({rs, rc, rov, rz} !== {32'd0, 1'b1, 1'b0, FLAGS}) begin
            miscompares++;
            $display("FAIL add_wrap: s=%h c=%b o=%b z=%b want 0 1 0 %b",
                     rs, rc, rov, rz, FLAGS);
        end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] rs; logic rc, rov, rz; int lat;
        run_one(32'h00FF_FFFF, 32'd0, 1'b0, 1'b1, rs, rc, rov, rz, lat);
        vectors++;
        if ({rs, rc, rov, rz} !== {32'h0100_0000, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL carry_ripple: s=%h c=%b o=%b z=%b want 01000000 0 0 0",
                     rs, rc, rov, rz);
        end
    endtask

    task automatic test_subtract();
        logic [31:0] rs; logic rc, rov, rz; int lat;
        run_one(32'h8000_0000, 32'd1, 1'b1, 1'b0, rs, rc, rov, rz, lat);
        vectors++;
        if ({rs, rc, rov, rz} !== {32'h7FFF_FFFF, 1'b1, FLAGS, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_ovf: s=%h c=%b o=%b z=%b want 7fffffff 1 %b 0",
                     rs, rc, rov, rz, FLAGS);
        end
        run_one(32'd3, 32'd5, 1'b1, 1'b0, rs, rc, rov, rz, lat);
        vectors++;
        if ({rs, rc, rov, rz} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_borrow: s=%h c=%b o=%b z=%b want fffffffe 0 0 0",
                     rs, rc, rov, rz);
        end
    endtask

    task automatic test_back_to_back();
        res_t        exp_q[$];
        res_t        e;
        int          issued = 0, got = 0, cyc = 0;
        logic        have = 1'b0, prev_stall = 1'b0, acc_in, acc_out;
        logic [31:0] px = '0, py = '0;
        logic        ps = 1'b0, pc = 1'b0;
        logic [35:0] snap = '0;
        while (got < 10 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (!have && issued < 10 && $urandom_range(3) != 0) begin
                px = $urandom; py = $urandom;
                ps = 1'($urandom_range(1)); pc = 1'($urandom_range(1));
                have = 1'b1;
            end
            m.in_valid = have; m.x = px; m.y = py; m.sub = ps; m.cin = pc;
            m.out_ready = 1'($urandom_range(1));
            #1;
            vectors++;
            if (m.in_ready !== !(m.out_valid && !m.out_ready)) begin
                miscompares++;
                $display("FAIL bp_in_ready: got %b with ov=%b ordy=%b",
                         m.in_ready, m.out_valid, m.out_ready);
            end
            if (prev_stall) begin
                vectors++;
                if ({m.out_valid, m.s, m.cout, m.ovf, m.zero} !== snap) begin
                    miscompares++;
                    $display("FAIL bp_stall_hold: got %h want %h",
                             {m.out_valid, m.s, m.cout, m.ovf, m.zero}, snap);
                end
            end
            acc_in  = m.in_valid && m.in_ready;
            acc_out = m.out_valid && m.out_ready;
            if (acc_out) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra_result: got s=%h want none", m.s);
                end else begin
                    e = exp_q.pop_front();
                    if ({m.s, m.cout, m.ovf, m.zero} !== {e.s[31:0], e.c, e.o, e.z}) begin
                        miscompares++;
                        $display("FAIL bp_result %0d: s=%h c=%b o=%b z=%b want %h %b %b %b",
                                 got, m.s, m.cout, m.ovf, m.zero,
                                 e.s[31:0], e.c, e.o, e.z);
                    end
                end
                got++;
            end
            if (acc_in) begin
                exp_q.push_back(ref_op(32, {32'd0, px}, {32'd0, py}, ps, pc));
                have = 1'b0;
                issued++;
            end
            prev_stall = m.out_valid && !m.out_ready;
            snap = {m.out_valid, m.s, m.cout, m.ovf, m.zero};
        end
        vectors++;
        if (got != 10) begin
            miscompares++;
            $display("FAIL bp_timeout: got %0d results want 10", got);
        end
        @(negedge clk);
        m.in_valid = 1'b0; m.out_ready = 1'b1;
    endtask

    task automatic test_sweep();
        logic [63:0] hx [80];
        logic [63:0] hy [80];
        logic        hs [80];
        logic        hc [80];
        logic        hv [80];
        res_t        e;
        int          j;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            hv[t] = (t < 60) && ($urandom_range(3) != 0);
            hx[t] = {$urandom, $urandom};
            hy[t] = {$urandom, $urandom};
            hs[t] = 1'($urandom_range(1));
            hc[t] = 1'($urandom_range(1));
            sw_valid = hv[t]; sw_x = hx[t]; sw_y = hy[t];
            sw_sub = hs[t]; sw_cin = hc[t];
            #1;
            for (int i = 0; i < 3; i++) begin
                j = t - SWS[i];
                vectors++;
                if (ro[i] !== 1'b1 || vo[i] !== (j >= 0 && hv[j])) begin
                    miscompares++;
                    $display("FAIL sweep_w%0d_valid t=%0d: v=%b rdy=%b want v=%b rdy=1",
                             SWW[i], t, vo[i], ro[i], (j >= 0 && hv[j]));
                end
                if (j >= 0 && hv[j]) begin
                    e = ref_op(SWW[i], hx[j], hy[j], hs[j], hc[j]);
                    vectors++;
                    if ({so[i], co[i], oo[i], zo[i]} !== e) begin
                        miscompares++;
                        $display("FAIL sweep_w%0d_data t=%0d: s=%h c=%b o=%b z=%b want %h %b %b %b",
                                 SWW[i], t, so[i], co[i], oo[i], zo[i],
                                 e.s, e.c, e.o, e.z);
                    end
                end
            end
        end
        sw_valid = 1'b0;
    endtask

    initial begin
        m.in_valid = 1'b0; m.out_ready = 1'b1;
        m.x = '0; m.y = '0; m.sub = 1'b0; m.cin = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_subtract();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units, want finish");
        $fatal(1, "watchdog");
    end
endmodule
